// File: rtl/ieee1355_ds_rx.sv
// IEEE1355 Data/Strobe receiver: recovers 10-bit characters from D/S lines.
// Latency: pin transition to rx_valid rise is G_SYNC_STAGES+2 clk cycles.
// Backpressure: one-deep holding register; a word finishing while it is still unread is dropped and rx_overflow pulses.
//
// Ports: clk, rst_n (async assert, deassert synchronized internally)
//        D_in, S_in    - asynchronous DS line inputs
//        rx_en         - receiver enable (0 forces IDLE)
//        rx_data/rx_valid/rx_ready - received character handshake, first bit in [9]
//        rx_overflow, ds_error, disconnect - single-cycle event pulses
//        link_active   - receiver is in RUN
module ieee1355_ds_rx #(
  parameter int G_DISC_TIMEOUT_CYC = 85,
  parameter int G_SYNC_STAGES      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       D_in,
  input  logic       S_in,
  input  logic       rx_en,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overflow,
  output logic       ds_error,
  output logic       disconnect,
  output logic       link_active
);

  localparam int TW = $clog2(G_DISC_TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(G_DISC_TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DISC} state_t;

  // Reset: asserts immediately, releases two clk edges after rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_i_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i_n = rst_sync[1];

  // Input synchronizers followed by a one-deep history register.
  logic [G_SYNC_STAGES-1:0] d_sync, s_sync;
  logic d_s, s_s, d_q, s_q;

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      d_sync <= '0;
      s_sync <= '0;
      d_q    <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      d_sync <= {d_sync[G_SYNC_STAGES-2:0], D_in};
      s_sync <= {s_sync[G_SYNC_STAGES-2:0], S_in};
      d_q    <= d_s;
      s_q    <= s_s;
    end
  end

  assign d_s = d_sync[G_SYNC_STAGES-1];
  assign s_s = s_sync[G_SYNC_STAGES-1];

  // Exactly one of D/S changes per bit, so D^S flips once per bit.
  // Both lines changing together leaves D^S unchanged and is a line error.
  logic bit_evt, both_tgl;
  assign bit_evt  = ((d_s ^ s_s) != (d_q ^ s_q));
  assign both_tgl = (d_s != d_q) && (s_s != s_q);

  state_t        state;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic          word_done;

  // The timer starts at 1 on the event edge so that it counts cycles since
  // the cycle in which the bit event was visible.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      word_done   <= 1'b0;
      ds_error    <= 1'b0;
      disconnect  <= 1'b0;
      link_active <= 1'b0;
    end else begin
      ds_error   <= both_tgl;
      disconnect <= 1'b0;
      word_done  <= 1'b0;
      if (!rx_en) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        timer       <= '0;
        link_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bit_evt) begin
              shreg       <= {shreg[8:0], d_s};
              bit_cnt     <= 4'd1;
              timer       <= TW'(1);
              state       <= RUN;
              link_active <= 1'b1;
            end
          end
          RUN: begin
            if (both_tgl) begin
              bit_cnt <= '0;
              timer   <= TW'(1);
            end else if (bit_evt) begin
              shreg <= {shreg[8:0], d_s};
              timer <= TW'(1);
              if (bit_cnt == 4'd9) begin
                bit_cnt   <= '0;
                word_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else if (timer == TIMEOUT_LAST) begin
              state       <= DISC;
              disconnect  <= 1'b1;
              link_active <= 1'b0;
              bit_cnt     <= '0;
              timer       <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          DISC: begin
            state       <= IDLE;
            link_active <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            link_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Holding register: accept-and-reload in one cycle keeps rx_valid high.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_overflow <= 1'b0;
      if (word_done) begin
        if (rx_valid && !rx_ready) begin
          rx_overflow <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ieee1355_ds_rx.sv
`timescale 1ns/1ps
module tb_ieee1355_ds_rx;

  localparam int SYNC = 2;
  localparam int TO   = 85;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       D_in, S_in;
  logic       rx_en, rx_ready;
  logic [9:0] rx_data;
  logic       rx_valid, rx_overflow, ds_error, disconnect, link_active;

  int checks = 0;
  int errors = 0;

  // Monitor state: written only by the monitor process.
  logic [9:0] rx_log [256];
  int rx_cnt = 0;
  int ovf_cnt = 0;
  int dserr_cnt = 0;
  int disc_cnt = 0;

  ieee1355_ds_rx #(
    .G_DISC_TIMEOUT_CYC(TO),
    .G_SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .D_in(D_in),
    .S_in(S_in),
    .rx_en(rx_en),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_overflow(rx_overflow),
    .ds_error(ds_error),
    .disconnect(disconnect),
    .link_active(link_active)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Records accepted characters and event pulses, sampled mid-low-phase.
  initial forever begin
    @(negedge clk);
    #1;
    if (rx_valid && rx_ready) begin
      if (rx_cnt < 256) rx_log[rx_cnt] = rx_data;
      rx_cnt++;
    end
    if (rx_overflow) ovf_cnt++;
    if (ds_error)    dserr_cnt++;
    if (disconnect)  disc_cnt++;
  end

  // DS encoding: D carries the bit; S toggles when D does not.
  task automatic drive_bit(input logic b);
    if (b != D_in) D_in = b;
    else           S_in = ~S_in;
  endtask

  task automatic send_bit(input logic b, input int per);
    drive_bit(b);
    repeat (per) @(negedge clk);
  endtask

  task automatic send_char(input logic [9:0] c);
    for (int i = 9; i >= 0; i--) send_bit(c[i], $urandom_range(2, 4));
  endtask

  task automatic drain;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; D_in = 1'b0; S_in = 1'b0; rx_en = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data got %h want 000", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if ({rx_overflow, ds_error, disconnect, link_active} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {rx_overflow, ds_error, disconnect, link_active}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single;
    logic [9:0] c;
    int base, b_ovf, b_ds, b_disc, lat;
    c = 10'b1111000011;
    base = rx_cnt; b_ovf = ovf_cnt; b_ds = dserr_cnt; b_disc = disc_cnt;
    for (int i = 9; i >= 1; i--) send_bit(c[i], 3);
    drive_bit(c[0]);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (rx_valid) lat = k;
    end
    // Synchronizer stages, then one cycle to shift the last bit, one to load.
    checks++; if (lat != SYNC + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, SYNC + 2); end
    drain;
    checks++; if (rx_cnt - base != 1) begin errors++; $display("FAIL single_count got %0d want 1", rx_cnt - base); end
    else begin
      checks++; if (rx_log[base] !== 10'h3C3) begin errors++; $display("FAIL single_data got %h want 3c3", rx_log[base]); end
    end
    checks++; if (ovf_cnt + dserr_cnt + disc_cnt != b_ovf + b_ds + b_disc) begin
      errors++; $display("FAIL single_err_pulses got %0d want 0", ovf_cnt + dserr_cnt + disc_cnt - b_ovf - b_ds - b_disc); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_q[$];
    int base;
    exp_q = '{10'b0011001100, 10'b1111111111, 10'b0000000000, 10'b1111111111};
    base = rx_cnt;
    foreach (exp_q[i]) send_char(exp_q[i]);
    drain;
    checks++; if (rx_cnt - base != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", rx_cnt - base, exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (rx_log[base + i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, rx_log[base + i], exp_q[i]); end
    end
  endtask

  task automatic test_random_stream;
    logic [9:0] exp_q[$];
    logic [9:0] c;
    int base, b_ds;
    base = rx_cnt; b_ds = dserr_cnt;
    for (int n = 0; n < 16; n++) begin
      c = 10'($urandom_range(0, 1023));
      exp_q.push_back(c);
      send_char(c);
    end
    drain;
    checks++; if (rx_cnt - base != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", rx_cnt - base, exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (rx_log[base + i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, rx_log[base + i], exp_q[i]); end
    end
    checks++; if (dserr_cnt != b_ds) begin errors++; $display("FAIL rand_ds_error got %0d want 0", dserr_cnt - b_ds); end
  endtask

  task automatic test_backpressure;
    int base, b_ovf;
    base = rx_cnt; b_ovf = ovf_cnt;
    rx_ready = 1'b0;
    send_char(10'h155);
    send_char(10'h2AA);
    drain;
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", rx_valid); end
    checks++; if (rx_data !== 10'h155) begin errors++; $display("FAIL bp_held_data got %h want 155", rx_data); end
    checks++; if (ovf_cnt - b_ovf != 1) begin errors++; $display("FAIL bp_overflow got %0d want 1", ovf_cnt - b_ovf); end
    rx_ready = 1'b1;
    drain;
    checks++; if (rx_cnt - base != 1) begin errors++; $display("FAIL bp_count got %0d want 1", rx_cnt - base); end
    else begin
      checks++; if (rx_log[base] !== 10'h155) begin errors++; $display("FAIL bp_data got %h want 155", rx_log[base]); end
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_clear got %b want 0", rx_valid); end
  endtask

  task automatic test_disconnect;
    logic [9:0] c;
    int base, b_disc, dly;
    c = 10'h3C3;
    base = rx_cnt; b_disc = disc_cnt;
    for (int i = 9; i >= 6; i--) send_bit(c[i], 3);
    drive_bit(c[5]);
    @(negedge clk);
    checks++; if (link_active !== 1'b1) begin errors++; $display("FAIL disc_link_before got %b want 1", link_active); end
    // Bit event is seen SYNC cycles after the pin; disconnect TO cycles after that.
    dly = -1;
    for (int k = 2; k <= 300 && dly < 0; k++) begin
      @(negedge clk);
      if (disconnect) dly = k;
    end
    checks++; if (dly != SYNC + TO) begin errors++; $display("FAIL disc_delay got %0d want %0d", dly, SYNC + TO); end
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL disc_link_after got %b want 0", link_active); end
    repeat (3) @(negedge clk);
    send_char(10'h3C3);
    drain;
    checks++; if (disc_cnt - b_disc != 1) begin errors++; $display("FAIL disc_pulses got %0d want 1", disc_cnt - b_disc); end
    checks++; if (rx_cnt - base != 1) begin errors++; $display("FAIL disc_count got %0d want 1", rx_cnt - base); end
    else begin
      checks++; if (rx_log[base] !== 10'h3C3) begin errors++; $display("FAIL disc_next_data got %h want 3c3", rx_log[base]); end
    end
  endtask

  task automatic test_ds_error;
    int base, b_ds;
    base = rx_cnt; b_ds = dserr_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 3);
    D_in = ~D_in;
    S_in = ~S_in;
    repeat (4) @(negedge clk);
    send_char(10'h3C3);
    drain;
    checks++; if (dserr_cnt - b_ds != 1) begin errors++; $display("FAIL dserr_pulses got %0d want 1", dserr_cnt - b_ds); end
    checks++; if (rx_cnt - base != 1) begin errors++; $display("FAIL dserr_count got %0d want 1", rx_cnt - base); end
    else begin
      checks++; if (rx_log[base] !== 10'h3C3) begin errors++; $display("FAIL dserr_realign got %h want 3c3", rx_log[base]); end
    end
  endtask

  task automatic test_rx_en;
    int base;
    base = rx_cnt;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 3);
    rx_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL rxen_link got %b want 0", link_active); end
    rx_en = 1'b1;
    @(negedge clk);
    send_char(10'h2AA);
    drain;
    checks++; if (rx_cnt - base != 1) begin errors++; $display("FAIL rxen_count got %0d want 1", rx_cnt - base); end
    else begin
      checks++; if (rx_log[base] !== 10'h2AA) begin errors++; $display("FAIL rxen_data got %h want 2aa", rx_log[base]); end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    base = rx_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 3);
    rst_n = 1'b0;
    D_in = 1'b0;
    S_in = 1'b0;
    #1;
    checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL rstmid_data got %h want 000", rx_data); end
    checks++; if ({rx_valid, rx_overflow, ds_error, disconnect, link_active} !== 5'b00000) begin
      errors++; $display("FAIL rstmid_flags got %b want 00000", {rx_valid, rx_overflow, ds_error, disconnect, link_active}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_char(10'h0CC);
    drain;
    checks++; if (rx_cnt - base != 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", rx_cnt - base); end
    else begin
      checks++; if (rx_log[base] !== 10'h0CC) begin errors++; $display("FAIL rstmid_data_after got %h want 0cc", rx_log[base]); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_random_stream;
    test_backpressure;
    test_disconnect;
    test_ds_error;
    test_rx_en;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
